// File: rtl/dom_and_pipe.sv
// Domain-oriented masked AND gadget for NSHARES Boolean shares.
// Cross terms are refreshed and registered before any share recombination.
module dom_and_pipe #(
    parameter int NSHARES = 2,
    parameter int WIDTH   = 1,
    parameter int OUT_REG = 0,
    localparam int NPAIRS = NSHARES * (NSHARES - 1) / 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NSHARES*WIDTH-1:0]   a_sh,
    input  logic [NSHARES*WIDTH-1:0]   b_sh,
    input  logic [NPAIRS*WIDTH-1:0]    z,
    input  logic                       z_valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NSHARES*WIDTH-1:0]   q_sh,
    output logic                       z_starve
);

    logic [WIDTH-1:0] t_d [NSHARES][NSHARES];
    logic [WIDTH-1:0] t_q [NSHARES][NSHARES];
    logic [NSHARES*WIDTH-1:0] q_c;
    logic v1;
    logic adv1;
    logic accept;

    // Diagonal holds the inner term, off-diagonal the refreshed cross terms.
    for (genvar i = 0; i < NSHARES; i++) begin : g_row
        for (genvar j = 0; j < NSHARES; j++) begin : g_col
            localparam int LO = (i < j) ? i : j;
            localparam int HI = (i < j) ? j : i;
            localparam int P  = LO * NSHARES - LO * (LO + 1) / 2 + (HI - LO - 1);
            if (i == j) begin : g_inner
                assign t_d[i][j] = a_sh[i*WIDTH +: WIDTH] & b_sh[i*WIDTH +: WIDTH];
            end else begin : g_cross
                assign t_d[i][j] = (a_sh[i*WIDTH +: WIDTH] & b_sh[j*WIDTH +: WIDTH])
                                 ^ z[P*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = !rst && (!v1 || adv1);
    assign accept   = in_valid && z_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            for (int i = 0; i < NSHARES; i++) begin
                for (int j = 0; j < NSHARES; j++) begin
                    t_q[i][j] <= '0;
                end
            end
        end else if (accept) begin
            v1  <= 1'b1;
            t_q <= t_d;
        end else if (adv1) begin
            v1 <= 1'b0;
        end
    end

    always_comb begin
        q_c = '0;
        for (int i = 0; i < NSHARES; i++) begin
            for (int j = 0; j < NSHARES; j++) begin
                q_c[i*WIDTH +: WIDTH] = q_c[i*WIDTH +: WIDTH] ^ t_q[i][j];
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic                     v2;
        logic [NSHARES*WIDTH-1:0] q2;

        assign adv1      = !v2 || out_ready;
        assign out_valid = v2;
        assign q_sh      = q2;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v2 <= 1'b0;
                q2 <= '0;
            end else if (v1 && adv1) begin
                v2 <= 1'b1;
                q2 <= q_c;
            end else if (out_ready) begin
                v2 <= 1'b0;
            end
        end
    end else begin : g_comb
        assign adv1      = out_ready;
        assign out_valid = v1;
        assign q_sh      = q_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_starve <= 1'b0;
        end else if (in_valid && !z_valid) begin
            z_starve <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dom_and_pipe.sv
// Bench for dom_and_pipe: a 2-share/8-bit comb-output instance and a
// 3-share/4-bit registered-output instance, scoreboard plus vector table.
module tb_dom_and_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv0 = 0, zv0 = 0, or0 = 1;
    logic        ir0, ov0, zs0;
    logic [15:0] a0 = 0, b0 = 0, q0;
    logic [7:0]  z0 = 0;

    logic        iv1 = 0, zv1 = 0, or1 = 1;
    logic        ir1, ov1, zs1;
    logic [11:0] a1 = 0, b1 = 0, z1 = 0, q1;

    dom_and_pipe #(.NSHARES(2), .WIDTH(8), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .a_sh(a0), .b_sh(b0), .z(z0), .z_valid(zv0),
        .out_valid(ov0), .out_ready(or0), .q_sh(q0), .z_starve(zs0)
    );

    dom_and_pipe #(.NSHARES(3), .WIDTH(4), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a_sh(a1), .b_sh(b1), .z(z1), .z_valid(zv1),
        .out_valid(ov1), .out_ready(or1), .q_sh(q1), .z_starve(zs1)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  z;
        logic [15:0] q;
    } vec_t;

    vec_t        vt [4];
    logic [15:0] sb0 [$];
    logic [3:0]  sb1 [$];
    int          checks = 0;
    int          fails  = 0;
    int          acc1   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model2(input logic [15:0] a, input logic [15:0] b,
                                           input logic [7:0] z);
        logic [7:0] s0, s1;
        s0 = (a[7:0] & b[7:0]) ^ (a[7:0] & b[15:8]) ^ z;
        s1 = (a[15:8] & b[15:8]) ^ (a[15:8] & b[7:0]) ^ z;
        return {s1, s0};
    endfunction

    function automatic logic [3:0] x3(input logic [11:0] s);
        return s[3:0] ^ s[7:4] ^ s[11:8];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (ov0 && or0) begin
                if (sb0.size() == 0) chk("sb0_spurious", 1, 0);
                else chk("sb0_q", q0, sb0.pop_front());
            end
            if (iv0 && zv0 && ir0) sb0.push_back(model2(a0, b0, z0));
            if (ov1 && or1) begin
                if (sb1.size() == 0) chk("sb1_spurious", 1, 0);
                else chk("sb1_xor", x3(q1), sb1.pop_front());
            end
            if (iv1 && zv1 && ir1) begin
                sb1.push_back(x3(a1) & x3(b1));
                acc1++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0] = '{16'hFF5A, 16'h0F3C, 8'h00, 16'h3312};
        vt[1] = '{16'hFF5A, 16'h0F3C, 8'hFF, 16'hCCED};
        vt[2] = '{16'h00FF, 16'hAA55, 8'h0F, 16'h0FF0};
        vt[3] = '{16'h1234, 16'h5678, 8'h9A, 16'h98BE};

        #2;
        chk("rst_ir0", ir0, 0);
        chk("rst_ov0", ov0, 0);
        chk("rst_q0", q0, 0);
        chk("rst_zs0", zs0, 0);
        chk("rst_ov1", ov1, 0);
        chk("rst_q1", q1, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("ir0_after_rst", ir0, 1);

        // single-shot vectors
        for (int k = 0; k < 4; k++) begin
            tick();
            a0 = vt[k].a; b0 = vt[k].b; z0 = vt[k].z;
            iv0 = 1; zv0 = 1; or0 = 1;
            tick();
            iv0 = 0;
            chk("vec_ov", ov0, 1);
            chk("vec_q", q0, vt[k].q);
            chk("vec_xor", q0[15:8] ^ q0[7:0],
                (vt[k].a[15:8] ^ vt[k].a[7:0]) & (vt[k].b[15:8] ^ vt[k].b[7:0]));
        end
        tick();

        // backpressure with a second op waiting at the input
        or0 = 0;
        a0 = vt[0].a; b0 = vt[0].b; z0 = vt[0].z; iv0 = 1; zv0 = 1;
        tick();
        a0 = vt[2].a; b0 = vt[2].b; z0 = vt[2].z;
        for (int k = 0; k < 3; k++) begin
            chk("stall_ov", ov0, 1);
            chk("stall_ir", ir0, 0);
            chk("stall_q", q0, vt[0].q);
            tick();
        end
        or0 = 1;
        tick();
        iv0 = 0;
        chk("bp_second_ov", ov0, 1);
        chk("bp_second_q", q0, vt[2].q);
        tick();
        chk("bp_empty", ov0, 0);

        // randomness starvation
        a0 = vt[3].a; b0 = vt[3].b; z0 = vt[3].z; iv0 = 1; zv0 = 0;
        tick();
        chk("starve_noacc", ov0, 0);
        chk("starve_set", zs0, 1);
        iv0 = 0; zv0 = 1;
        tick();
        chk("starve_sticky", zs0, 1);
        iv0 = 1;
        tick();
        iv0 = 0;
        chk("starve_acc_ov", ov0, 1);
        chk("starve_acc_q", q0, vt[3].q);
        tick();

        // registered-output latency
        a1 = 12'hA5C; b1 = 12'h3F1; z1 = 12'h7B2; iv1 = 1; zv1 = 1; or1 = 1;
        tick();
        iv1 = 0;
        chk("lat2_c1", ov1, 0);
        tick();
        chk("lat2_c2", ov1, 1);
        chk("lat2_xor", x3(q1), x3(12'hA5C) & x3(12'h3F1));
        tick();
        chk("lat2_empty", ov1, 0);

        // random traffic
        acc1 = 0;
        for (int c = 0; c < 20000 && acc1 < 1000; c++) begin
            iv1 = $urandom_range(0, 3) != 0;
            zv1 = $urandom_range(0, 7) != 0;
            or1 = $urandom_range(0, 3) != 0;
            a1 = 12'($urandom); b1 = 12'($urandom); z1 = 12'($urandom);
            tick();
        end
        iv1 = 0; or1 = 1;
        chk("rand_ops", acc1 >= 1000, 1);
        for (int c = 0; c < 20 && sb1.size() != 0; c++) tick();
        chk("rand_drain", sb1.size(), 0);

        // reset with ops in flight
        a0 = vt[1].a; b0 = vt[1].b; z0 = vt[1].z; iv0 = 1; zv0 = 1; or0 = 0;
        a1 = 12'h123; b1 = 12'h456; iv1 = 1; zv1 = 1; or1 = 0;
        tick();
        iv0 = 0; iv1 = 0;
        tick();
        chk("pre_rst_ov0", ov0, 1);
        #2 rst = 1;
        #1;
        chk("mid_rst_ov0", ov0, 0);
        chk("mid_rst_q0", q0, 0);
        chk("mid_rst_zs0", zs0, 0);
        chk("mid_rst_ir0", ir0, 0);
        chk("mid_rst_ov1", ov1, 0);
        chk("mid_rst_q1", q1, 0);
        chk("mid_rst_zs1", zs1, 0);
        sb0.delete();
        sb1.delete();
        tick();
        rst = 0; or0 = 1; or1 = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_ov0", ov0, 0);
            chk("post_rst_ov1", ov1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
